// File: rtl/ring_input_buffer.sv
// Write side of the ring router's priority buffers: ring-transit packets fill the
// high-priority bank, locally injected packets fill the low-priority bank, and the
// switch allocator frees slots by grant. Slot arrays and route codes feed the allocator.

// One priority bank: first-empty-slot write, route tagging, and grant-driven free.
module ring_buffer_bank #(
  parameter int unsigned PACKET_SIZE = 49,
  parameter int unsigned BUFFER_SIZE = 4,
  parameter logic [15:0] ROUTER_ID   = 16'h0,
  parameter logic [15:0] RING_PORT   = 16'h1,
  parameter logic [15:0] LOCAL_PORT  = 16'h2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [PACKET_SIZE-1:0]               in_packet,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 grant_valid,
  input  logic [15:0]                          grant_pos,
  output logic [PACKET_SIZE-1:0]               slots      [BUFFER_SIZE],
  output logic [15:0]                          route_info [BUFFER_SIZE],
  output logic [$clog2(BUFFER_SIZE+1)-1:0]     count,
  output logic                                 illegal_grant_c
);

  localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned IDX_W = $clog2(BUFFER_SIZE);
  localparam logic [15:0] BS16  = 16'(BUFFER_SIZE);
  localparam logic [PACKET_SIZE-1:0] VALID_MASK = {1'b1, {(PACKET_SIZE-1){1'b0}}};

  logic [PACKET_SIZE-1:0] slots_nxt [BUFFER_SIZE];
  logic [15:0]            route_nxt [BUFFER_SIZE];
  logic [CNT_W-1:0]       count_nxt;
  logic [IDX_W-1:0]       wr_idx;
  logic [IDX_W-1:0]       free_idx;
  logic                   found;
  logic                   write_c;
  logic                   free_c;

  // Next-state: the write target is chosen from pre-edge occupancy, so it never
  // collides with a slot being freed on the same edge.
  always_comb begin
    slots_nxt       = slots;
    route_nxt       = route_info;
    wr_idx          = '0;
    found           = 1'b0;
    free_idx        = grant_pos[IDX_W-1:0];
    free_c          = grant_valid && (grant_pos < BS16) && slots[free_idx][PACKET_SIZE-1];
    illegal_grant_c = grant_valid && !free_c;

    for (int unsigned i = 0; i < BUFFER_SIZE; i++) begin
      if (!found && !slots[i][PACKET_SIZE-1]) begin
        found  = 1'b1;
        wr_idx = IDX_W'(i);
      end
    end

    write_c = in_valid && in_ready && found;

    if (free_c) begin
      slots_nxt[free_idx] = '0;
      route_nxt[free_idx] = '0;
    end

    if (write_c) begin
      slots_nxt[wr_idx] = in_packet | VALID_MASK;
      route_nxt[wr_idx] = (in_packet[31:16] == ROUTER_ID) ? LOCAL_PORT : RING_PORT;
    end

    count_nxt = count + CNT_W'(write_c) - CNT_W'(free_c);
  end

  // State registers; ready is registered from the next count so it tracks count exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUFFER_SIZE; i++) begin
        slots[i]      <= '0;
        route_info[i] <= '0;
      end
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      slots      <= slots_nxt;
      route_info <= route_nxt;
      count      <= count_nxt;
      in_ready   <= (count_nxt < CNT_W'(BUFFER_SIZE));
    end
  end

endmodule

// Top: two independent banks sharing one grant port, plus the sticky grant error flag.
module ring_input_buffer #(
  parameter int unsigned PACKET_SIZE = 49,
  parameter int unsigned BUFFER_SIZE = 4,
  parameter logic [15:0] ROUTER_ID   = 16'h0,
  parameter logic [15:0] RING_PORT   = 16'h1,
  parameter logic [15:0] LOCAL_PORT  = 16'h2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PACKET_SIZE-1:0]           ring_in_packet,
  input  logic                             ring_in_valid,
  output logic                             ring_in_ready,
  input  logic [PACKET_SIZE-1:0]           local_in_packet,
  input  logic                             local_in_valid,
  output logic                             local_in_ready,
  input  logic                             grant_valid,
  input  logic [15:0]                      grant_pos,
  input  logic                             grant_in_high,
  output logic [PACKET_SIZE-1:0]           buffer_high_prior            [BUFFER_SIZE],
  output logic [15:0]                      buffer_high_prior_route_info [BUFFER_SIZE],
  output logic [PACKET_SIZE-1:0]           buffer_low_prior             [BUFFER_SIZE],
  output logic [15:0]                      buffer_low_prior_route_info  [BUFFER_SIZE],
  output logic [$clog2(BUFFER_SIZE+1)-1:0] high_count,
  output logic [$clog2(BUFFER_SIZE+1)-1:0] low_count,
  output logic                             grant_error
);

  logic high_grant_c;
  logic low_grant_c;
  logic high_illegal_c;
  logic low_illegal_c;

  assign high_grant_c = grant_valid &&  grant_in_high;
  assign low_grant_c  = grant_valid && !grant_in_high;

  ring_buffer_bank #(
    .PACKET_SIZE (PACKET_SIZE),
    .BUFFER_SIZE (BUFFER_SIZE),
    .ROUTER_ID   (ROUTER_ID),
    .RING_PORT   (RING_PORT),
    .LOCAL_PORT  (LOCAL_PORT)
  ) u_high (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_packet       (ring_in_packet),
    .in_valid        (ring_in_valid),
    .in_ready        (ring_in_ready),
    .grant_valid     (high_grant_c),
    .grant_pos       (grant_pos),
    .slots           (buffer_high_prior),
    .route_info      (buffer_high_prior_route_info),
    .count           (high_count),
    .illegal_grant_c (high_illegal_c)
  );

  ring_buffer_bank #(
    .PACKET_SIZE (PACKET_SIZE),
    .BUFFER_SIZE (BUFFER_SIZE),
    .ROUTER_ID   (ROUTER_ID),
    .RING_PORT   (RING_PORT),
    .LOCAL_PORT  (LOCAL_PORT)
  ) u_low (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_packet       (local_in_packet),
    .in_valid        (local_in_valid),
    .in_ready        (local_in_ready),
    .grant_valid     (low_grant_c),
    .grant_pos       (grant_pos),
    .slots           (buffer_low_prior),
    .route_info      (buffer_low_prior_route_info),
    .count           (low_count),
    .illegal_grant_c (low_illegal_c)
  );

  // Sticky error: any grant to an out-of-range or empty slot, held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_error <= 1'b0;
    end else if (high_illegal_c || low_illegal_c) begin
      grant_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ring_input_buffer.sv
// Directed bench for ring_input_buffer with ROUTER_ID=5.
module tb_ring_input_buffer;

  localparam int unsigned PS = 49;
  localparam int unsigned BS = 4;

  logic          clk;
  logic          rst_n;
  logic [PS-1:0] ring_in_packet;
  logic          ring_in_valid;
  logic          ring_in_ready;
  logic [PS-1:0] local_in_packet;
  logic          local_in_valid;
  logic          local_in_ready;
  logic          grant_valid;
  logic [15:0]   grant_pos;
  logic          grant_in_high;
  logic [PS-1:0] buffer_high_prior            [BS];
  logic [15:0]   buffer_high_prior_route_info [BS];
  logic [PS-1:0] buffer_low_prior             [BS];
  logic [15:0]   buffer_low_prior_route_info  [BS];
  logic [2:0]    high_count;
  logic [2:0]    low_count;
  logic          grant_error;

  int n_checks = 0;
  int n_fail   = 0;

  ring_input_buffer #(
    .PACKET_SIZE (PS),
    .BUFFER_SIZE (BS),
    .ROUTER_ID   (16'h5),
    .RING_PORT   (16'h1),
    .LOCAL_PORT  (16'h2)
  ) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .ring_in_packet               (ring_in_packet),
    .ring_in_valid                (ring_in_valid),
    .ring_in_ready                (ring_in_ready),
    .local_in_packet              (local_in_packet),
    .local_in_valid               (local_in_valid),
    .local_in_ready               (local_in_ready),
    .grant_valid                  (grant_valid),
    .grant_pos                    (grant_pos),
    .grant_in_high                (grant_in_high),
    .buffer_high_prior            (buffer_high_prior),
    .buffer_high_prior_route_info (buffer_high_prior_route_info),
    .buffer_low_prior             (buffer_low_prior),
    .buffer_low_prior_route_info  (buffer_low_prior_route_info),
    .high_count                   (high_count),
    .low_count                    (low_count),
    .grant_error                  (grant_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packet as a sender presents it (valid bit deliberately 0; the buffer sets it).
  function automatic logic [PS-1:0] mk(input logic [15:0] ts, input logic [15:0] dest,
                                       input logic [15:0] payload);
    return {1'b0, ts, dest, payload};
  endfunction

  function automatic logic [PS-1:0] stored(input logic [PS-1:0] p);
    return {1'b1, p[PS-2:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [PS-1:0] p0, p1, p2, p3, p4, l0, l1, l2, r6, l6;

  initial begin
    p0 = mk(16'h0010, 16'h0007, 16'hA000);
    p1 = mk(16'h0011, 16'h0005, 16'hA001);
    p2 = mk(16'h0012, 16'h0007, 16'hA002);
    p3 = mk(16'h0013, 16'h0007, 16'hA003);
    p4 = mk(16'h0014, 16'h0005, 16'hA004);
    l0 = mk(16'h0020, 16'h0005, 16'hB000);
    l1 = mk(16'h0021, 16'h0009, 16'hB001);
    l2 = mk(16'h0022, 16'h0007, 16'hB002);
    r6 = mk(16'h0030, 16'h0005, 16'hC000);
    l6 = mk(16'h0031, 16'h0008, 16'hC001);

    rst_n           = 1'b0;
    ring_in_packet  = '0;
    ring_in_valid   = 1'b0;
    local_in_packet = '0;
    local_in_valid  = 1'b0;
    grant_valid     = 1'b0;
    grant_pos       = '0;
    grant_in_high   = 1'b0;

    // 1: reset state
    #12;
    chk("rst_high_count", 64'(high_count), 64'd0);
    chk("rst_low_count",  64'(low_count),  64'd0);
    chk("rst_grant_error", 64'(grant_error), 64'd0);
    chk("rst_high_slot0", 64'(buffer_high_prior[0]), 64'd0);
    chk("rst_low_route3", 64'(buffer_low_prior_route_info[3]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_ring_ready",  64'(ring_in_ready),  64'd1);
    chk("rst_local_ready", 64'(local_in_ready), 64'd1);

    // 2: fill high buffer, dest 7,5,7,7 -> route 1,2,1,1
    ring_in_valid  = 1'b1;
    ring_in_packet = p0;
    tick();
    chk("fill_slot0", 64'(buffer_high_prior[0]), 64'(stored(p0)));
    chk("fill_route0", 64'(buffer_high_prior_route_info[0]), 64'd1);
    chk("fill_count1", 64'(high_count), 64'd1);
    ring_in_packet = p1;
    tick();
    chk("fill_slot1", 64'(buffer_high_prior[1]), 64'(stored(p1)));
    chk("fill_route1", 64'(buffer_high_prior_route_info[1]), 64'd2);
    ring_in_packet = p2;
    tick();
    ring_in_packet = p3;
    tick();
    chk("fill_slot2", 64'(buffer_high_prior[2]), 64'(stored(p2)));
    chk("fill_route2", 64'(buffer_high_prior_route_info[2]), 64'd1);
    chk("fill_slot3", 64'(buffer_high_prior[3]), 64'(stored(p3)));
    chk("fill_route3", 64'(buffer_high_prior_route_info[3]), 64'd1);
    chk("fill_count4", 64'(high_count), 64'd4);
    chk("fill_ready0", 64'(ring_in_ready), 64'd0);
    ring_in_packet = p4;
    tick();
    chk("held_count", 64'(high_count), 64'd4);
    chk("held_slot3", 64'(buffer_high_prior[3]), 64'(stored(p3)));
    chk("held_ready", 64'(ring_in_ready), 64'd0);

    // 3: full + grant pos 2 -> free only; write lands next cycle
    grant_valid   = 1'b1;
    grant_pos     = 16'd2;
    grant_in_high = 1'b1;
    tick();
    chk("fullgrant_slot2", 64'(buffer_high_prior[2]), 64'd0);
    chk("fullgrant_route2", 64'(buffer_high_prior_route_info[2]), 64'd0);
    chk("fullgrant_count", 64'(high_count), 64'd3);
    chk("fullgrant_ready", 64'(ring_in_ready), 64'd1);
    grant_valid = 1'b0;
    tick();
    chk("refill_slot2", 64'(buffer_high_prior[2]), 64'(stored(p4)));
    chk("refill_route2", 64'(buffer_high_prior_route_info[2]), 64'd2);
    chk("refill_count", 64'(high_count), 64'd4);
    ring_in_valid = 1'b0;

    // 4: low buffer write + free same cycle
    local_in_valid  = 1'b1;
    local_in_packet = l0;
    tick();
    local_in_packet = l1;
    tick();
    chk("low_count2", 64'(low_count), 64'd2);
    chk("low_route1", 64'(buffer_low_prior_route_info[1]), 64'd1);
    local_in_packet = l2;
    grant_valid     = 1'b1;
    grant_pos       = 16'd0;
    grant_in_high   = 1'b0;
    tick();
    chk("wf_slot0", 64'(buffer_low_prior[0]), 64'd0);
    chk("wf_slot1", 64'(buffer_low_prior[1]), 64'(stored(l1)));
    chk("wf_slot2", 64'(buffer_low_prior[2]), 64'(stored(l2)));
    chk("wf_route2", 64'(buffer_low_prior_route_info[2]), 64'd1);
    chk("wf_count", 64'(low_count), 64'd2);
    chk("wf_high_untouched", 64'(high_count), 64'd4);
    chk("wf_no_error", 64'(grant_error), 64'd0);
    local_in_valid = 1'b0;

    // 5: illegal grants
    grant_pos = 16'd3;
    tick();
    chk("ill_empty_err", 64'(grant_error), 64'd1);
    chk("ill_empty_count", 64'(low_count), 64'd2);
    grant_pos = 16'd9;
    tick();
    chk("ill_range_err", 64'(grant_error), 64'd1);
    chk("ill_range_count", 64'(low_count), 64'd2);
    chk("ill_range_slot1", 64'(buffer_low_prior[1]), 64'(stored(l1)));
    grant_valid = 1'b0;
    tick();
    chk("ill_sticky", 64'(grant_error), 64'd1);

    // 6: free one high slot (3 high + 2 low), then async reset mid-cycle
    grant_valid   = 1'b1;
    grant_pos     = 16'd0;
    grant_in_high = 1'b1;
    tick();
    grant_valid = 1'b0;
    chk("pre_rst_high", 64'(high_count), 64'd3);
    chk("pre_rst_low",  64'(low_count),  64'd2);
    ring_in_valid  = 1'b1;
    ring_in_packet = r6;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_high_count", 64'(high_count), 64'd0);
    chk("arst_low_count",  64'(low_count),  64'd0);
    chk("arst_high_slot1", 64'(buffer_high_prior[1]), 64'd0);
    chk("arst_low_slot2",  64'(buffer_low_prior[2]), 64'd0);
    chk("arst_error", 64'(grant_error), 64'd0);
    @(negedge clk);
    rst_n           = 1'b1;
    local_in_valid  = 1'b1;
    local_in_packet = l6;
    tick();
    chk("post_rst_high_slot0", 64'(buffer_high_prior[0]), 64'(stored(r6)));
    chk("post_rst_high_route0", 64'(buffer_high_prior_route_info[0]), 64'd2);
    chk("post_rst_low_slot0", 64'(buffer_low_prior[0]), 64'(stored(l6)));
    chk("post_rst_low_route0", 64'(buffer_low_prior_route_info[0]), 64'd1);
    chk("post_rst_counts", 64'({high_count, low_count}), 64'({3'd1, 3'd1}));
    ring_in_valid  = 1'b0;
    local_in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
